eq_band_mixer: RTL and testbench

Per-band gain and summing stage of the digital audio equalizer. Sits directly downstream of the 10-band FIR filter bank (`fir_all_filters`). It captures the ten band outputs on a sample strobe and multiplies each by a programmable signed gain. The products are accumulated serially over one MAC per cycle, then the sum is rounded and saturated back to one 24-bit audio sample.

---
 rtl/eq_band_mixer_if.sv | 39 +++
 rtl/eq_band_mixer.sv | 140 ++++++++++++++
 tb/tb_eq_band_mixer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_band_mixer_if.sv
// rtl/eq_band_mixer_if.sv - band sample, gain write and mixed-output bundle for eq_band_mixer
interface eq_band_mixer_if #(
   parameter int DATA_W = 24,
   parameter int GAIN_W = 16
);
   logic                     sample_valid;
   logic signed [DATA_W-1:0] band_lowpass;
   logic signed [DATA_W-1:0] band_64_125;
   logic signed [DATA_W-1:0] band_125_250;
   logic signed [DATA_W-1:0] band_250_500;
   logic signed [DATA_W-1:0] band_500_1k;
   logic signed [DATA_W-1:0] band_1k_2k;
   logic signed [DATA_W-1:0] band_2k_4k;
   logic signed [DATA_W-1:0] band_4k_8k;
   logic signed [DATA_W-1:0] band_8k_16k;
   logic signed [DATA_W-1:0] band_highpass;
   logic                     gain_we;
   logic [3:0]               gain_addr;
   logic signed [GAIN_W-1:0] gain_data;
   logic signed [DATA_W-1:0] audio_out;
   logic                     out_valid;
   logic                     sat_flag;
   logic                     busy;
   logic                     overrun;

   modport master (
      output sample_valid, band_lowpass, band_64_125, band_125_250, band_250_500,
             band_500_1k, band_1k_2k, band_2k_4k, band_4k_8k, band_8k_16k, band_highpass,
             gain_we, gain_addr, gain_data,
      input  audio_out, out_valid, sat_flag, busy, overrun
   );

   modport slave (
      input  sample_valid, band_lowpass, band_64_125, band_125_250, band_250_500,
             band_500_1k, band_1k_2k, band_2k_4k, band_4k_8k, band_8k_16k, band_highpass,
             gain_we, gain_addr, gain_data,
      output audio_out, out_valid, sat_flag, busy, overrun
   );
endinterface

// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - per-band gain, serial MAC and rounding/saturating mix to one sample
module eq_band_mixer #(
   parameter int DATA_W    = 24,
   parameter int GAIN_W    = 16,
   parameter int GAIN_FRAC = 14
) (
   input  logic            clk,
   input  logic            rst_n,
   eq_band_mixer_if.slave  bus
);
   localparam int NB     = 10;
   localparam int PROD_W = DATA_W + GAIN_W;
   localparam int ACC_W  = PROD_W + 4;

   localparam logic signed [GAIN_W-1:0] UNITY   = GAIN_W'(1) << GAIN_FRAC;
   localparam logic signed [ACC_W-1:0]  HALF    = ACC_W'(1) << (GAIN_FRAC - 1);
   localparam logic signed [ACC_W-1:0]  OUT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0]  OUT_MIN = -OUT_MAX - ACC_W'(1);

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   state_t                   state, state_nx;
   logic [3:0]               k;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] snap      [NB];
   logic signed [DATA_W-1:0] band_in   [NB];
   logic signed [GAIN_W-1:0] shadow    [NB];
   logic signed [GAIN_W-1:0] shadow_nx [NB];
   logic signed [GAIN_W-1:0] active    [NB];
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  rnd;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [DATA_W-1:0] clipped;
   logic                     sat_nx;
   logic                     accept;

   always_comb begin
      band_in[0] = bus.band_lowpass;
      band_in[1] = bus.band_64_125;
      band_in[2] = bus.band_125_250;
      band_in[3] = bus.band_250_500;
      band_in[4] = bus.band_500_1k;
      band_in[5] = bus.band_1k_2k;
      band_in[6] = bus.band_2k_4k;
      band_in[7] = bus.band_4k_8k;
      band_in[8] = bus.band_8k_16k;
      band_in[9] = bus.band_highpass;
   end

   // Write merged in before the copy so a write on the accept cycle reaches the active bank.
   always_comb begin
      for (int i = 0; i < NB; i++) begin
         shadow_nx[i] = shadow[i];
      end
      if (bus.gain_we && (bus.gain_addr < 4'd10)) begin
         shadow_nx[bus.gain_addr] = bus.gain_data;
      end
   end

   assign accept = (state == IDLE) && bus.sample_valid;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.sample_valid) state_nx = ACC;
         ACC:     if (k == 4'd9)        state_nx = OUT;
         OUT:                           state_nx = IDLE;
         default:                       state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   assign prod = snap[k] * active[k];

   // Round half toward +inf, then clip to the signed output range.
   always_comb begin
      rnd     = acc + HALF;
      shifted = rnd >>> GAIN_FRAC;
      sat_nx  = 1'b0;
      clipped = shifted[DATA_W-1:0];
      if (shifted > OUT_MAX) begin
         clipped = OUT_MAX[DATA_W-1:0];
         sat_nx  = 1'b1;
      end else if (shifted < OUT_MIN) begin
         clipped = OUT_MIN[DATA_W-1:0];
         sat_nx  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k             <= '0;
         acc           <= '0;
         bus.audio_out <= '0;
         bus.out_valid <= 1'b0;
         bus.sat_flag  <= 1'b0;
         bus.busy      <= 1'b0;
         bus.overrun   <= 1'b0;
         for (int i = 0; i < NB; i++) begin
            snap[i]   <= '0;
            shadow[i] <= UNITY;
            active[i] <= UNITY;
         end
      end else begin
         bus.out_valid <= 1'b0;
         bus.overrun   <= bus.sample_valid && (state != IDLE);
         for (int i = 0; i < NB; i++) begin
            shadow[i] <= shadow_nx[i];
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  for (int i = 0; i < NB; i++) begin
                     snap[i]   <= band_in[i];
                     active[i] <= shadow_nx[i];
                  end
                  acc      <= '0;
                  k        <= '0;
                  bus.busy <= 1'b1;
               end
            end
            ACC: begin
               acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
               k   <= k + 4'd1;
            end
            OUT: begin
               bus.audio_out <= clipped;
               bus.sat_flag  <= sat_nx;
               bus.out_valid <= 1'b1;
               bus.busy      <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_eq_band_mixer.sv
// tb/tb_eq_band_mixer.sv - scoreboard bench for eq_band_mixer against an arithmetic mixing model
module tb_eq_band_mixer;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   eq_band_mixer_if #(.DATA_W(24), .GAIN_W(16)) bus ();
   eq_band_mixer #(.DATA_W(24), .GAIN_W(16), .GAIN_FRAC(14)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic signed [23:0] audio;
      logic               sat;
   } exp_t;

   exp_t exp_q[$];
   int   shadow_m[10];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   next_ok = 0;
   int   ov_exp = 0;
   int   ov_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic exp_t model(input int b[10], input int g[10]);
      longint sum = 0;
      longint num, q;
      exp_t   e;
      for (int i = 0; i < 10; i++) sum += longint'(b[i]) * longint'(g[i]);
      num = sum + 8192;
      q   = num / 16384;
      if ((num % 16384 != 0) && (num < 0)) q = q - 1;
      e.sat = 1'b0;
      if (q > 8388607) begin
         q = 8388607;
         e.sat = 1'b1;
      end else if (q < -8388608) begin
         q = -8388608;
         e.sat = 1'b1;
      end
      e.audio = 24'(q);
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.overrun) ov_seen++;
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out_valid: got audio %0d expected no output", bus.audio_out);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("audio_out", bus.audio_out, e.audio);
               check("sat_flag", bus.sat_flag, e.sat);
            end
         end
      end
   end

   // Called at posedge+1; the inputs are sampled at the following edge.
   task automatic drive(input bit strobe, input int b[10], input bit gw, input int ga, input int gd);
      bus.band_lowpass  = 24'(b[0]);
      bus.band_64_125   = 24'(b[1]);
      bus.band_125_250  = 24'(b[2]);
      bus.band_250_500  = 24'(b[3]);
      bus.band_500_1k   = 24'(b[4]);
      bus.band_1k_2k    = 24'(b[5]);
      bus.band_2k_4k    = 24'(b[6]);
      bus.band_4k_8k    = 24'(b[7]);
      bus.band_8k_16k   = 24'(b[8]);
      bus.band_highpass = 24'(b[9]);
      bus.sample_valid  = strobe;
      bus.gain_we       = gw;
      bus.gain_addr     = 4'(ga);
      bus.gain_data     = 16'(gd);
      if (gw && ga < 10) shadow_m[ga] = gd;
      if (strobe) begin
         if (cyc + 1 >= next_ok) begin
            exp_q.push_back(model(b, shadow_m));
            next_ok = cyc + 1 + 12;
         end else begin
            ov_exp++;
         end
      end
      @(posedge clk);
      #1;
      bus.sample_valid = 1'b0;
      bus.gain_we      = 1'b0;
   endtask

   function automatic void fill(output int b[10], input int v);
      for (int i = 0; i < 10; i++) b[i] = v;
   endfunction

   task automatic idle(input int n);
      int z[10];
      fill(z, 0);
      repeat (n) drive(1'b0, z, 1'b0, 0, 0);
   endtask

   task automatic set_gain(input int a, input int g);
      int z[10];
      fill(z, 0);
      drive(1'b0, z, 1'b1, a, g);
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         idle(1);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout_out_valid: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic one_sample(input int b[10], input longint req, input string name);
      drive(1'b1, b, 1'b0, 0, 0);
      wait_done();
      check(name, bus.audio_out, req);
   endtask

   initial begin
      int b[10];
      int cnt;
      int ov_before;

      rst_n = 1'b0;
      fill(b, 0);
      bus.sample_valid = 1'b0;
      bus.gain_we = 1'b0;
      bus.gain_addr = '0;
      bus.gain_data = '0;
      for (int i = 0; i < 10; i++) shadow_m[i] = 16384;
      repeat (3) @(posedge clk);
      #1;
      check("reset_audio_out", bus.audio_out, 0);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_sat_flag", bus.sat_flag, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_overrun", bus.overrun, 0);
      rst_n = 1'b1;
      idle(2);

      fill(b, 1000);
      drive(1'b1, b, 1'b0, 0, 0);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
         cnt++;
      end
      check("busy_cycles", cnt, 11);
      @(posedge clk);
      #1;
      wait_done();
      check("unity_sum", bus.audio_out, 10000);

      set_gain(3, 8192);
      fill(b, 0);
      b[3] = 4000;
      one_sample(b, 2000, "half_gain_band3");
      set_gain(0, -16384);
      fill(b, 0);
      b[0] = 500;
      one_sample(b, -500, "neg_gain_band0");

      set_gain(0, 8192);
      set_gain(3, 0);
      fill(b, 0);
      b[0] = 3;
      one_sample(b, 2, "round_pos3");
      b[0] = -3;
      one_sample(b, -1, "round_neg3");
      b[0] = 1;
      one_sample(b, 1, "round_pos1");

      set_gain(0, 16384);
      set_gain(3, 16384);
      fill(b, 8388607);
      one_sample(b, 8388607, "sat_pos");
      check("sat_pos_flag", bus.sat_flag, 1);
      fill(b, -8388608);
      one_sample(b, -8388608, "sat_neg");
      check("sat_neg_flag", bus.sat_flag, 1);
      fill(b, 1000);
      one_sample(b, 10000, "sat_cleared");
      check("sat_cleared_flag", bus.sat_flag, 0);

      ov_before = ov_seen;
      fill(b, 100);
      drive(1'b1, b, 1'b0, 0, 0);
      idle(4);
      drive(1'b1, b, 1'b1, 0, 0);
      wait_done();
      check("overrun_isolated", bus.audio_out, 1000);
      check("overrun_pulses", ov_seen - ov_before, 1);
      one_sample(b, 900, "gain_after_overrun");

      set_gain(2, 0);
      fill(b, 100);
      drive(1'b1, b, 1'b0, 0, 0);
      idle(5);
      rst_n = 1'b0;
      exp_q.delete();
      next_ok = 0;
      for (int i = 0; i < 10; i++) shadow_m[i] = 16384;
      #1;
      check("rst_mid_audio", bus.audio_out, 0);
      check("rst_mid_out_valid", bus.out_valid, 0);
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_sat", bus.sat_flag, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      fill(b, 10);
      one_sample(b, 100, "after_reset_unity");

      for (int it = 0; it < 40; it++) begin
         bit full = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 10; i++)
            b[i] = full ? int'($signed(24'($urandom))) : int'($urandom_range(0, 8000)) - 4000;
         if ($urandom_range(0, 1) == 1)
            drive(1'b1, b, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)) - 32768);
         else
            drive(1'b1, b, 1'b0, 0, 0);
         idle(int'($urandom_range(0, 14)));
      end
      wait_done();
      idle(2);
      check("overrun_total", ov_seen, ov_exp);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
